serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. One full-adder cell plus a carry flop adds two
// WIDTH-bit operands LSB first, one bit per clock, behind a start/busy/done
// handshake. Reports the raw carry-out of the MSB and signed overflow.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined     -> sub=1 at start computes a - b as a + ~b + 1 (cin ignored)
//   not defined -> sub is ignored; the datapath is a pure adder
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit counter only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             c_msb;

  // Operand/carry values loaded on an accepted start.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is two's-complement addition: invert b and force carry-in.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
  end
`else
  // Addition only; sub is present for port compatibility and has no effect.
  logic unused_sub;
  assign unused_sub = sub;

  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  // The single full-adder cell operating on the current LSBs.
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] psum_next;
  logic             last_step;

  always_comb begin
    s_bit     = a_sr[0] ^ b_sr[0] ^ c;
    c_next    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    psum_next = {s_bit, psum[WIDTH-1:1]};
    last_step = (cnt == LAST_BIT);
  end

  // Control FSM and datapath registers; outputs are registered and only
  // change on the completing edge (results) or on start/complete (handshake).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      c_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          // DONE lasts exactly one cycle; a start seen here runs back-to-back.
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            c     <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          psum <= psum_next;
          c    <= c_next;
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            // Carry into the MSB is the current c; carry out is c_next.
            c_msb <= c;
            sum   <= psum_next;
            cout  <= c_next;
            ovf   <= c ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): scoreboard of expected results
// pushed at each accepted start, popped and compared at each done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int t_start  = 0;
  logic [W+1:0] held;          // {ovf,cout,sum} expected to stay put during RUN
  logic [W+1:0] sb[$];         // expected {ovf,cout,sum}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain integer addition on the effective operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] eb;
    logic         c0;
    logic [W:0]   full;
    logic         v;
`ifdef SERIAL_ADDER_SUB_EN
    eb = msub ? ~mb : mb;
    c0 = msub ? 1'b1 : mcin;
`else
    eb = mb;
    c0 = mcin;
    if (msub) c0 = mcin;
`endif
    full = {1'b0, ma} + {1'b0, eb} + {{W{1'b0}}, c0};
    v = (ma[W-1] == eb[W-1]) && (full[W-1] != ma[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input logic [W+1:0] exp);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    sb.push_back(exp);
    held = {ovf, cout, sum};
    tick();
    start = 1'b0;
    t_start = cyc;
    check("start busy", 64'(busy), 64'(1'b1));
    check("start done", 64'(done), 64'(1'b0));
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [W+1:0] exp;
    n = 0;
    while (done !== 1'b1 && n < W + 4) begin
      check({tag, " hold"}, 64'({ovf, cout, sum}), 64'(held));
      check({tag, " busy"}, 64'(busy), 64'(1'b1));
      tick();
      n++;
    end
    check({tag, " done seen"}, 64'(done), 64'(1'b1));
    check({tag, " latency"}, 64'(cyc - t_start), 64'(W));
    check({tag, " busy low"}, 64'(busy), 64'(1'b0));
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 64'(0), 64'(1));
    end else begin
      exp = sb.pop_front();
      check({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
      check({tag, " cout"}, 64'(cout), 64'(exp[W]));
      check({tag, " ovf"}, 64'(ovf), 64'(exp[W+1]));
    end
    $display("op %s: sum=%0h cout=%0b ovf=%0b", tag, sum, cout, ovf);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'(1'b0));
    check("rst done", 64'(done), 64'(1'b0));
    check("rst sum",  64'(sum),  64'(0));
    check("rst cout", 64'(cout), 64'(1'b0));
    check("rst ovf",  64'(ovf),  64'(1'b0));
    #2 rst_n = 1'b1;

    // FF + 01: wraps to 00 with carry out, no signed overflow.
    issue(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    wait_done("ff+01");
    tick();
    check("ff+01 done pulse", 64'(done), 64'(1'b0));

    // 7F + 01 overflows; then 03+05+1 issued back-to-back in the DONE cycle.
    issue(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    wait_done("7f+01");
    issue(8'h03, 8'h05, 1'b1, 1'b0, {1'b0, 1'b0, 8'h09});
    wait_done("03+05+1");
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE});
    wait_done("05-07");
    tick();
    issue(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    wait_done("80-01");
    tick();
`else
    issue(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'h0C});
    wait_done("sub ignored");
    tick();
`endif

    // start pulsed during RUN must be ignored.
    issue(8'h10, 8'h20, 1'b0, 1'b0, {1'b0, 1'b0, 8'h30});
    tick(); tick();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignored start");
    tick();

    // Asynchronous reset in the middle of RUN: everything clears, no done.
    issue(8'h55, 8'h22, 1'b0, 1'b0, {1'b0, 1'b0, 8'h77});
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'(1'b0));
    check("abort sum",  64'(sum),  64'(0));
    check("abort done", 64'(done), 64'(1'b0));
    void'(sb.pop_back());
    repeat (W + 2) begin
      tick();
      check("abort no done", 64'(done), 64'(1'b0));
    end
    #2 rst_n = 1'b1;
    tick();
    issue(8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02});
    wait_done("01+01");

    // A few back-to-back random additions against the model.
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
      wait_done("random");
    end
    tick();

    check("scoreboard empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
